// File: rtl/mopshub_uplink_buffer.sv
// Show-ahead FIFO of CAN messages for the elink uplink. Head is presented one cycle after push into empty.
// Backpressure: irq_elink_rec/elink_ack valid-ready; a strobe into a full queue without a pop is dropped and counted.
module mopshub_uplink_buffer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [75:0] can_rec_data,
  input  logic [4:0]  can_rec_select,
  input  logic        can_rec_strobe,
  input  logic        flush,
  output logic [75:0] data_rec_uplink,
  output logic [4:0]  bus_id_uplink,
  output logic        irq_elink_rec,
  input  logic        elink_ack,
  output logic [6:0]  fill_level,
  output logic        full,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic        stall_flag
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {EMPTY, PRESENT, STALLED} state_t;

  state_t        state;
  logic [80:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          pop, push_ok, drop;
  logic [6:0]    fill_nxt;
  logic [80:0]   head;

  always_comb begin
    pop      = irq_elink_rec & elink_ack;
    push_ok  = can_rec_strobe & (~full | pop);
    drop     = can_rec_strobe & full & ~pop;
    rd_nxt   = rd_ptr + PW'(pop);
    fill_nxt = fill_level + 7'(push_ok) - 7'(pop);
    // The incoming message becomes head when nothing older survives this edge.
    head     = (push_ok && fill_level == 7'(pop)) ? {can_rec_select, can_rec_data} : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok)
      mem[wr_ptr] <= {can_rec_select, can_rec_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= EMPTY;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      tmo_cnt         <= '0;
      fill_level      <= '0;
      full            <= 1'b0;
      overflow        <= 1'b0;
      drop_cnt        <= '0;
      stall_flag      <= 1'b0;
      irq_elink_rec   <= 1'b0;
      data_rec_uplink <= '0;
      bus_id_uplink   <= '0;
    end else if (flush) begin
      state           <= EMPTY;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      tmo_cnt         <= '0;
      fill_level      <= '0;
      full            <= 1'b0;
      overflow        <= 1'b0;
      stall_flag      <= 1'b0;
      irq_elink_rec   <= 1'b0;
      data_rec_uplink <= '0;
      bus_id_uplink   <= '0;
    end else begin
      rd_ptr     <= rd_nxt;
      wr_ptr     <= wr_ptr + PW'(push_ok);
      fill_level <= fill_nxt;
      full       <= (fill_nxt == 7'(DEPTH));
      overflow   <= drop;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;

      if (fill_nxt == 7'd0) begin
        state         <= EMPTY;
        irq_elink_rec <= 1'b0;
        tmo_cnt       <= '0;
      end else begin
        irq_elink_rec <= 1'b1;
        if (pop || state == EMPTY) begin
          state           <= PRESENT;
          tmo_cnt         <= '0;
          data_rec_uplink <= head[75:0];
          bus_id_uplink   <= head[80:76];
        end else if (state == PRESENT) begin
          if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state      <= STALLED;
            stall_flag <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mopshub_uplink_buffer.sv
// Scoreboard bench for mopshub_uplink_buffer (DEPTH=8, TIMEOUT=16).
module tb_mopshub_uplink_buffer;

  logic        clk_40_m = 1'b0;
  logic        rst = 1'b1;
  logic [75:0] can_rec_data = '0;
  logic [4:0]  can_rec_select = '0;
  logic        can_rec_strobe = 1'b0;
  logic        flush = 1'b0;
  logic        elink_ack = 1'b0;
  logic [75:0] data_rec_uplink;
  logic [4:0]  bus_id_uplink;
  logic        irq_elink_rec;
  logic [6:0]  fill_level;
  logic        full;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        stall_flag;

  int n_chk = 0;
  int n_pass = 0;
  logic [80:0] exp_q [$];
  logic [75:0] base;

  always #12.5 clk_40_m = ~clk_40_m;

  mopshub_uplink_buffer #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk_40_m), .rst(rst),
    .can_rec_data(can_rec_data), .can_rec_select(can_rec_select),
    .can_rec_strobe(can_rec_strobe), .flush(flush),
    .data_rec_uplink(data_rec_uplink), .bus_id_uplink(bus_id_uplink),
    .irq_elink_rec(irq_elink_rec), .elink_ack(elink_ack),
    .fill_level(fill_level), .full(full), .overflow(overflow),
    .drop_cnt(drop_cnt), .stall_flag(stall_flag)
  );

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every handshake must deliver the oldest outstanding expected message.
  always @(negedge clk_40_m) begin
    if (!rst && irq_elink_rec && elink_ack) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got %0h expected nothing", {bus_id_uplink, data_rec_uplink});
      end else begin
        if ({bus_id_uplink, data_rec_uplink} === exp_q[0]) n_pass++;
        else $display("FAIL pop_data: got %0h expected %0h", {bus_id_uplink, data_rec_uplink}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_40_m);
    #1;
  endtask

  task automatic strobe(input logic [4:0] bus, input logic [75:0] dat, input logic ack, input bit accepted);
    can_rec_select = bus;
    can_rec_data   = dat;
    can_rec_strobe = 1'b1;
    elink_ack      = ack;
    if (accepted) exp_q.push_back({bus, dat});
    tick();
    can_rec_strobe = 1'b0;
    elink_ack      = 1'b0;
  endtask

  task automatic drain(input int n);
    elink_ack = 1'b1;
    repeat (n) tick();
    elink_ack = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_irq"},   81'(irq_elink_rec), 81'(0));
    chk({tag, "_fill"},  81'(fill_level), 81'(0));
    chk({tag, "_full"},  81'(full), 81'(0));
    chk({tag, "_ovf"},   81'(overflow), 81'(0));
    chk({tag, "_drop"},  81'(drop_cnt), 81'(0));
    chk({tag, "_stall"}, 81'(stall_flag), 81'(0));
    chk({tag, "_head"},  {bus_id_uplink, data_rec_uplink}, 81'(0));
  endtask

  initial begin
    base = 76'h2345_6789_ABCD_EF01_234;

    // Reset for two cycles
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_state("reset");

    // Three strobes, no ack: head appears one cycle after first strobe and holds
    strobe(5'd1, base, 1'b0, 1'b1);
    chk("lat_irq", 81'(irq_elink_rec), 81'(1));
    chk("lat_head", {bus_id_uplink, data_rec_uplink}, {5'd1, base});
    strobe(5'd2, base, 1'b0, 1'b1);
    strobe(5'd3, base, 1'b0, 1'b1);
    chk("fill3", 81'(fill_level), 81'(3));
    chk("hold_bus", 81'(bus_id_uplink), 81'(1));
    drain(3);
    chk("drain3_irq", 81'(irq_elink_rec), 81'(0));
    chk("drain3_fill", 81'(fill_level), 81'(0));

    // Ten strobes into DEPTH=8: last two dropped
    for (int i = 0; i < 10; i++) begin
      strobe(5'(i + 4), base + 76'(i), 1'b0, i < 8);
      if (i == 7) begin
        chk("full_after8", 81'(full), 81'(1));
        chk("fill8", 81'(fill_level), 81'(8));
      end
      if (i >= 8) chk("ovf_pulse", 81'(overflow), 81'(1));
    end
    tick();
    chk("ovf_clear", 81'(overflow), 81'(0));
    chk("drop2", 81'(drop_cnt), 81'(2));
    drain(8);
    chk("ovf_drain_empty", 81'(exp_q.size()), 81'(0));
    chk("ovf_drain_irq", 81'(irq_elink_rec), 81'(0));

    // Full queue with simultaneous push/pop, across the pointer wrap
    for (int i = 0; i < 8; i++) strobe(5'd9, base ^ 76'(i << 8), 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      strobe(5'(16 + i), base + 76'(100 + i), 1'b1, 1'b1);
      chk("pp_no_ovf", 81'(overflow), 81'(0));
      chk("pp_fill8", 81'(fill_level), 81'(8));
    end
    chk("pp_drop", 81'(drop_cnt), 81'(2));
    drain(8);
    chk("pp_drain_empty", 81'(exp_q.size()), 81'(0));
    chk("pp_drain_fill", 81'(fill_level), 81'(0));

    // Consumer timeout sets sticky stall_flag; flush clears it
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pre_stall", 81'(stall_flag), 81'(0));
    strobe(5'd7, base + 76'd7, 1'b0, 1'b1);
    repeat (15) tick();
    chk("stall_not_yet", 81'(stall_flag), 81'(0));
    tick();
    chk("stall_set", 81'(stall_flag), 81'(1));
    chk("stall_irq_held", 81'(irq_elink_rec), 81'(1));
    drain(1);
    chk("stall_sticky", 81'(stall_flag), 81'(1));
    chk("stall_popped_irq", 81'(irq_elink_rec), 81'(0));
    flush = 1'b1; tick(); flush = 1'b0;
    chk("stall_flushed", 81'(stall_flag), 81'(0));

    // Flush with a concurrent strobe discards everything, no drop counted
    for (int i = 0; i < 5; i++) strobe(5'd2, base + 76'(200 + i), 1'b0, 1'b0);
    chk("fill5", 81'(fill_level), 81'(5));
    flush = 1'b1;
    strobe(5'd3, base, 1'b0, 1'b0);
    flush = 1'b0;
    chk("flush_fill", 81'(fill_level), 81'(0));
    chk("flush_irq", 81'(irq_elink_rec), 81'(0));
    chk("flush_drop", 81'(drop_cnt), 81'(2));
    chk("flush_ovf", 81'(overflow), 81'(0));

    // Reset mid-queue
    for (int i = 0; i < 3; i++) strobe(5'd5, base + 76'(300 + i), 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset_state("midrst");
    tick();
    chk("midrst_idle_irq", 81'(irq_elink_rec), 81'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
